// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one req/rvalid memory between instruction fetch and the LSU
// Optional: define MIRISCV_MEM_ARB_RR_EN for round-robin arbitration (default: data beats instr).
module miriscv_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_t;

  state_t        state;
  port_t         owner;
  port_t         winner;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          resp;
`ifdef MIRISCV_MEM_ARB_RR_EN
  port_t         last_grant;
`endif

  always_comb begin
    winner = PORT_INSTR;
`ifdef MIRISCV_MEM_ARB_RR_EN
    if (data_req_i && instr_req_i)
      winner = (last_grant == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    else if (data_req_i)
      winner = PORT_DATA;
`else
    if (data_req_i)
      winner = PORT_DATA;
`endif
  end

  // A response arriving on the final timeout cycle takes precedence over the forced error.
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign resp           = (state == WAIT) && (mem_rvalid_i || timeout_hit);
  assign err_o          = (state == WAIT) && timeout_hit && !mem_rvalid_i;
  assign busy_o         = (state != IDLE);
  assign instr_rvalid_o = resp && (owner == PORT_INSTR);
  assign data_rvalid_o  = resp && (owner == PORT_DATA);
  assign instr_rdata_o  = (instr_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
  assign data_rdata_o   = (data_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      owner       <= PORT_INSTR;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
`ifdef MIRISCV_MEM_ARB_RR_EN
      last_grant  <= PORT_INSTR;
`endif
    end else begin
      mem_req_o <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_req_i || data_req_i) begin
            owner     <= winner;
            mem_req_o <= 1'b1;
            state     <= ISSUE;
            if (winner == PORT_DATA) begin
              mem_we_o    <= data_we_i;
              mem_be_o    <= data_be_i;
              mem_addr_o  <= data_addr_i;
              mem_wdata_o <= data_wdata_i;
            end else begin
              mem_we_o    <= 1'b0;
              mem_be_o    <= '1;
              mem_addr_o  <= instr_addr_i;
              mem_wdata_o <= '0;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (resp) begin
            state <= IDLE;
`ifdef MIRISCV_MEM_ARB_RR_EN
            last_grant <= owner;
`endif
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - scoreboard bench for miriscv_mem_arbiter
module tb_miriscv_mem_arbiter;
  localparam int XLEN = 32;
  localparam logic [31:0] IDLE_RDATA = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        arstn_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = IDLE_RDATA;
  logic        busy_o;
  logic        err_o;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  mreq_t exp_req[$];
  resp_t exp_resp[$];
  int passed = 0;
  int total = 0;

  miriscv_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: memory beats and port responses are popped as the DUT produces them.
  always @(negedge clk) begin
    if (arstn_i) begin
      if (mem_req_o) begin
        mreq_t e, a;
        total = total + 1;
        a = {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
        if (exp_req.size() == 0) begin
          $display("FAIL mem_req_unexpected: got we=%0b be=%h addr=%h wdata=%h, expected no request",
                   a.we, a.be, a.addr, a.wdata);
        end else begin
          e = exp_req.pop_front();
          if (a !== e)
            $display("FAIL mem_req: got we=%0b be=%h addr=%h wdata=%h, expected we=%0b be=%h addr=%h wdata=%h",
                     a.we, a.be, a.addr, a.wdata, e.we, e.be, e.addr, e.wdata);
          else
            passed = passed + 1;
        end
      end
      if (instr_rvalid_o || data_rvalid_o) begin
        resp_t e, a;
        logic [31:0] other;
        total = total + 1;
        a = {data_rvalid_o, data_rvalid_o ? data_rdata_o : instr_rdata_o, err_o};
        other = data_rvalid_o ? instr_rdata_o : data_rdata_o;
        if (instr_rvalid_o && data_rvalid_o) begin
          $display("FAIL resp_both: got instr_rvalid=1 data_rvalid=1, expected one port only");
        end else if (exp_resp.size() == 0) begin
          $display("FAIL resp_unexpected: got port=%0d rdata=%h err=%0b, expected no response",
                   a.port, a.rdata, a.err);
        end else begin
          e = exp_resp.pop_front();
          if (a !== e || other !== 32'h0)
            $display("FAIL resp: got port=%0d rdata=%h err=%0b other_rdata=%h, expected port=%0d rdata=%h err=%0b other_rdata=0",
                     a.port, a.rdata, a.err, other, e.port, e.rdata, e.err);
          else
            passed = passed + 1;
        end
      end else if (err_o) begin
        total = total + 1;
        $display("FAIL err_alone: got err_o=1 without rvalid, expected err only with a response");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total = total + 1;
    if (!ok) $display("FAIL wait_issue: got no mem_req_o in 10 cycles, expected a request beat");
    else passed = passed + 1;
  endtask

  // Enters at the requesting cycle, returns in the IDLE cycle after the response.
  task automatic serve(input int lat, input logic [31:0] rdata);
    bit ok;
    wait_issue(ok);
    if (!ok) return;
    for (int i = 0; i < lat; i++) step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
  endtask

  task automatic check_quiet(input string name);
    logic [139:0] outs;
    outs = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o, err_o,
            instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o};
    total = total + 1;
    if (outs !== '0) $display("FAIL %s: got outputs=%h, expected all zero", name, outs);
    else passed = passed + 1;
  endtask

  task automatic test_reset();
    #2 arstn_i = 1'b0;
    mem_rvalid_i = 1'b1;
    #1 check_quiet("reset_outputs");
    step();
    step();
    mem_rvalid_i = 1'b0;
    arstn_i = 1'b1;
    step();
    check_quiet("post_reset_idle");
  endtask

  task automatic test_instr_read();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h80;
    exp_req.push_back({1'b0, 4'hF, 32'h80, 32'h0});
    exp_resp.push_back({1'b0, 32'h13, 1'b0});
    step();
    total = total + 1;
    if (mem_req_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL instr_latency: got mem_req=%0b busy=%0b, expected 1 1", mem_req_o, busy_o);
    else passed = passed + 1;
    step();
    total = total + 1;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL instr_pulse: got mem_req=%0b busy=%0b, expected 0 1", mem_req_o, busy_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h13;
    #1;
    total = total + 1;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h13)
      $display("FAIL instr_resp: got rvalid=%0b rdata=%h, expected 1 00000013", instr_rvalid_o, instr_rdata_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    instr_req_i  = 1'b0;
    total = total + 1;
    if (busy_o !== 1'b0) $display("FAIL instr_done: got busy=%0b, expected 0", busy_o);
    else passed = passed + 1;
  endtask

  task automatic test_data_write();
    bit ok;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0011;
    data_addr_i  = 32'h100;
    data_wdata_i = 32'hDEAD;
    exp_req.push_back({1'b1, 4'b0011, 32'h100, 32'hDEAD});
    exp_resp.push_back({1'b1, 32'h0, 1'b0});
    wait_issue(ok);
    data_addr_i  = 32'h999;
    data_wdata_i = 32'hBEEF;
    data_be_i    = 4'hF;
    data_we_i    = 1'b0;
    step();
    total = total + 1;
    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'b0011, 32'h100, 32'hDEAD})
      $display("FAIL write_hold: got we=%0b be=%h addr=%h wdata=%h, expected 1 3 00000100 0000dead",
               mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    data_req_i   = 1'b0;
  endtask

  task automatic test_back_to_back();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h8;
    exp_req.push_back({1'b0, 4'hF, 32'h8, 32'h0});
    exp_resp.push_back({1'b0, 32'hA1, 1'b0});
    serve(1, 32'hA1);
    instr_addr_i = 32'hC;
    exp_req.push_back({1'b0, 4'hF, 32'hC, 32'h0});
    exp_resp.push_back({1'b0, 32'hA2, 1'b0});
    step();
    total = total + 1;
    if (mem_req_o !== 1'b1)
      $display("FAIL back_to_back: got mem_req=%0b one cycle after IDLE, expected 1", mem_req_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA2;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    instr_req_i  = 1'b0;
  endtask

  task automatic test_arbitration();
`ifdef MIRISCV_MEM_ARB_RR_EN
    logic [2:0] order = 3'b101;
`else
    logic [2:0] order = 3'b111;
`endif
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h84;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_be_i    = 4'b1100;
    data_addr_i  = 32'h200;
    data_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (order[i]) exp_req.push_back({1'b0, 4'b1100, 32'h200, 32'h0});
      else          exp_req.push_back({1'b0, 4'hF, 32'h84, 32'h0});
      exp_resp.push_back({order[i], 32'h1000 + i, 1'b0});
      serve(1 + (i % 2), 32'h1000 + i);
    end
    instr_req_i = 1'b0;
    data_req_i  = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h300;
    exp_req.push_back({1'b0, 4'hF, 32'h300, 32'h0});
    exp_resp.push_back({1'b0, 32'h0, 1'b1});
    wait_issue(ok);
    for (int w = 1; w <= 4; w++) begin
      step();
      total = total + 1;
      if (w < 4) begin
        if (err_o !== 1'b0 || instr_rvalid_o !== 1'b0 || busy_o !== 1'b1)
          $display("FAIL timeout_wait%0d: got err=%0b rvalid=%0b busy=%0b, expected 0 0 1",
                   w, err_o, instr_rvalid_o, busy_o);
        else passed = passed + 1;
      end else begin
        if (err_o !== 1'b1 || instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0)
          $display("FAIL timeout_fire: got err=%0b rvalid=%0b rdata=%h, expected 1 1 00000000",
                   err_o, instr_rvalid_o, instr_rdata_o);
        else passed = passed + 1;
      end
    end
    step();
    instr_req_i = 1'b0;
    total = total + 1;
    if (busy_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL timeout_idle: got busy=%0b err=%0b, expected 0 0", busy_o, err_o);
    else passed = passed + 1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h99;
    #1;
    total = total + 1;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0)
      $display("FAIL late_rvalid: got instr=%0b data=%0b, expected 0 0", instr_rvalid_o, data_rvalid_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
  endtask

  task automatic test_timeout_race();
    bit ok;
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h400;
    exp_req.push_back({1'b0, 4'hF, 32'h400, 32'h0});
    exp_resp.push_back({1'b1, 32'h77, 1'b0});
    wait_issue(ok);
    for (int w = 1; w <= 4; w++) step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h77;
    #1;
    total = total + 1;
    if (err_o !== 1'b0 || data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h77)
      $display("FAIL timeout_race: got err=%0b rvalid=%0b rdata=%h, expected 0 1 00000077",
               err_o, data_rvalid_o, data_rdata_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    data_req_i   = 1'b0;
  endtask

  task automatic test_spurious();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h44;
    #1;
    total = total + 1;
    if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL spurious_idle: got instr=%0b data=%0b busy=%0b, expected 0 0 0",
               instr_rvalid_o, data_rvalid_o, busy_o);
    else passed = passed + 1;
    step();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h500;
    exp_req.push_back({1'b0, 4'hF, 32'h500, 32'h0});
    exp_resp.push_back({1'b0, 32'h55, 1'b0});
    step();
    total = total + 1;
    if (mem_req_o !== 1'b1 || instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0)
      $display("FAIL spurious_issue: got mem_req=%0b instr=%0b data=%0b, expected 1 0 0",
               mem_req_o, instr_rvalid_o, data_rvalid_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    #1;
    total = total + 1;
    if (busy_o !== 1'b1) $display("FAIL spurious_wait: got busy=%0b, expected 1", busy_o);
    else passed = passed + 1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = IDLE_RDATA;
    instr_req_i  = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h600;
    exp_req.push_back({1'b0, 4'hF, 32'h600, 32'h0});
    wait_issue(ok);
    step();
    arstn_i = 1'b0;
    #1 check_quiet("reset_mid_wait");
    step();
    arstn_i = 1'b1;
    exp_req.push_back({1'b0, 4'hF, 32'h600, 32'h0});
    exp_resp.push_back({1'b1, 32'h66, 1'b0});
    serve(2, 32'h66);
    data_req_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_data_write();
    test_back_to_back();
    test_arbitration();
    test_timeout();
    test_timeout_race();
    test_spurious();
    test_reset_mid();
    step();
    total = total + 1;
    if (exp_req.size() != 0 || exp_resp.size() != 0)
      $display("FAIL drain: got %0d requests and %0d responses outstanding, expected 0 0",
               exp_req.size(), exp_resp.size());
    else passed = passed + 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
